hex_display_scan: RTL and testbench
===================================

# hex_display_scan

Time-multiplexed driver for the board's common-anode 7-segment display. It takes the N-bit value selected for display, splits it into N/4 hex digits, and scans them one at a time onto shared, active-low segment lines. It sits directly downstream of the display source multiplexer and drives the anode and cathode pins.

## Interface

Parameters:
- `N`, 16: width of the displayed value; must be a multiple of 4; DIGITS = N/4.
- `REFRESH_DIV`, 100_000: clock cycles per digit slot; must be greater than GUARD + 1.
- `GUARD`, 2_000: cycles at the start of each slot with all anodes off, for anti-ghosting.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `ToDisplay` in N: value to show.
- `blank_lz` in 1: 1 enables leading-zero blanking.
- `dp_mask` in DIGITS: bit i = 1 lights the decimal point of digit i.
- `anodes` out DIGITS: digit enables, active low; bit 0 is the rightmost digit.
- `segments` out 7: cathodes, active low; bit 0 = a … bit 6 = g.
- `dp` out 1: decimal-point cathode, active low.
- `frame_done` out 1: one-cycle pulse when a full scan frame completes.

## Operation

- The FSM has three states: LOAD, GUARD_S, SHOW.
- The shadow register `shadow[N-1:0]` and the latched `lz_en` / `dp_q` are captured only in LOAD. A mid-frame change of `ToDisplay` therefore never tears a frame.
- LOAD (1 cycle):
  - Capture the inputs, set digit index `idx` = 0 and prescaler `cnt` = 0.
  - Go to GUARD_S.
- GUARD_S:
  - All anodes are off.
  - `cnt` increments each cycle.
  - When `cnt` = GUARD-1, go to SHOW.
- SHOW:
  - Drive digit `idx`. `cnt` keeps incrementing.
  - When `cnt` = REFRESH_DIV-1, set `cnt` to 0, then:
    - If `idx` < DIGITS-1: `idx`++ and go to GUARD_S.
    - If `idx` = DIGITS-1: pulse `frame_done` and go to LOAD.
- Leading-zero blanking: digit i (i > 0) is blanked when `lz_en`=1 and every nibble from i up to DIGITS-1 is 0.
  - Digit 0 is never blanked, so a value of 0 shows "0".
  - A blanked digit has its anode off, and its segments and dp off.
- Hex decode (hex value: gfedcba):
  - 0: 40, 1: 79, 2: 24, 3: 30
  - 4: 19, 5: 12, 6: 02, 7: 78
  - 8: 00, 9: 10, A: 08, b: 03
  - C: 46, d: 21, E: 06, F: 0E
- `dp` = ~`dp_q[idx]` while in SHOW and the digit is not blanked; otherwise 1.

## Timing

- Reset values:
  - State LOAD, `cnt`=0, `idx`=0, `shadow`=0.
  - `anodes`=all 1, `segments`=7'h7F, `dp`=1, `frame_done`=0.
- Reset asserted mid-frame: outputs go to their reset values immediately (asynchronous). The first LOAD happens on the first clock edge after reset is released.
- All outputs are registered and lag the FSM state by 1 cycle. The first anode goes low at cycle 1 + GUARD + 1 after leaving reset.
- Slot length is exactly REFRESH_DIV cycles, of which the first GUARD cycles are the guard interval.
- Frame length is DIGITS × REFRESH_DIV + 1 cycles (LOAD included).
- `frame_done` is high for exactly 1 cycle. It is registered and coincides with the output cycle of LOAD.
- At most one anode is low in any cycle.
- `cnt` is sized as $clog2(REFRESH_DIV); `idx` is sized as $clog2(DIGITS), with a minimum of 1 bit.

## Structure

- Package `display_pkg` contains:
  - `state_t` enum {LOAD, GUARD_S, SHOW};
  - the `SEG_BLANK` = 7'h7F constant;
  - the 16-entry hex-to-segment constant table.
- Sub-module `hex_to_7seg`: purely combinational; 4-bit nibble in, 7-bit active-low segments out, using the table from the package.

## Test plan

All scenarios use N=16, REFRESH_DIV=8, GUARD=2.

- Reset, then `ToDisplay`=16'h12AF, `blank_lz`=0 → the slot sequence is:
  - `anodes` = 1110 / 1101 / 1011 / 0111;
  - `segments` = 0E, 08, 24, 79 respectively;
  - guard cycles show 1111; frame length is 33 cycles; `frame_done` pulses once per frame.
- `ToDisplay`=16'h0005, `blank_lz`=1 → only digit 0 lights, with `segments`=12; slots 1–3 keep `anodes`=1111. `ToDisplay`=0 → digit 0 shows 40.
- Change `ToDisplay` from 16'h1111 to 16'h2222 mid-frame → the rest of that frame still shows 1 (79); the next frame shows 2 (24).
- `dp_mask`=4'b0100 → `dp`=0 only during digit 2's show cycles; 1 everywhere else.
- Assert `reset` during digit 2's slot → in the same cycle `anodes`=1111, `segments`=7F, `dp`=1. After release, scanning restarts at digit 0 after LOAD + guard.
- Continuous check over 4 frames → never more than one anode low at a time; `frame_done` spacing is exactly 33 cycles.

Source files
------------

// File: rtl/display_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared types and constants for the 7-segment scan driver:
//                FSM state encoding, the all-off segment pattern and the
//                hex-to-segment (gfedcba, active-low) lookup table.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

   // Scan FSM states
   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      GUARD_S = 2'd1,
      SHOW    = 2'd2
   } state_t;

   // All cathodes released (active low)
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Entry k is the active-low gfedcba pattern for hex digit k
   // (listed from F down to 0 because the leftmost element is the MSB slice)
   localparam logic [15:0][6:0] HEX_SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

endpackage
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : hex_to_7seg
//  Description : Combinational decode of one hex nibble into active-low
//                segment drives (bit 0 = a ... bit 6 = g).
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_to_7seg
   import display_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg_n
);

   // Straight table lookup; every nibble value has a defined glyph
   always_comb begin
      o_seg_n = HEX_SEG_TABLE[i_nibble];
   end

endmodule
`default_nettype wire

// File: rtl/hex_display_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : hex_display_scan
//  Description : Time-multiplexed driver for a common-anode 7-segment display.
//                Shadows the value once per frame, then scans each hex digit
//                through a guard (all anodes off) and a show interval.
//                Optional leading-zero blanking and per-digit decimal points.
//                All pin outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_display_scan
   import display_pkg::*;
#(
   parameter int N           = 16,
   parameter int REFRESH_DIV = 100_000,
   parameter int GUARD       = 2_000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     ToDisplay,
   input  logic             blank_lz,
   input  logic [N/4-1:0]   dp_mask,
   output logic [N/4-1:0]   anodes,
   output logic [6:0]       segments,
   output logic             dp,
   output logic             frame_done
);

   localparam int c_digits = N / 4;
   localparam int c_cnt_w  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int c_idx_w  = (c_digits > 1) ? $clog2(c_digits) : 1;

   localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
   localparam logic [c_cnt_w-1:0] c_guard_last = c_cnt_w'(GUARD - 1);
   localparam logic [c_cnt_w-1:0] c_slot_last  = c_cnt_w'(REFRESH_DIV - 1);
   localparam logic [c_idx_w-1:0] c_idx_one    = c_idx_w'(1);
   localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(c_digits - 1);

   // FSM and frame-shadow state
   state_t                state_q,  state_d;
   logic [c_cnt_w-1:0]    cnt_q,    cnt_d;
   logic [c_idx_w-1:0]    idx_q,    idx_d;
   logic [N-1:0]          shadow_q, shadow_d;
   logic                  lz_en_q,  lz_en_d;
   logic [c_digits-1:0]   dp_q,     dp_d;
   // Set when the last slot of a frame ends; turned into frame_done in LOAD
   logic                  pend_q,   pend_d;

   // Registered pin drives
   logic [c_digits-1:0]   anodes_q,     anodes_d;
   logic [6:0]            segments_q,   segments_d;
   logic                  dp_out_q,     dp_out_d;
   logic                  frame_done_q, frame_done_d;

   // Current-digit selections
   logic [3:0]            w_nibble;
   logic [6:0]            w_seg;
   logic [c_digits-1:0]   w_blank;
   logic [c_digits-1:0]   w_onehot;
   logic                  w_blank_cur;
   logic                  w_dp_cur;

   // Leading-zero mask: digit i blanks when it and all digits above are zero
   always_comb begin
      logic upper_zero;
      w_blank    = '0;
      upper_zero = 1'b1;
      for (int i = c_digits - 1; i >= 0; i--) begin
         upper_zero = upper_zero & (shadow_q[i*4 +: 4] == 4'h0);
         if (i > 0) begin
            w_blank[i] = lz_en_q & upper_zero;
         end
      end
   end

   // Select the nibble, blank flag, dp bit and anode position of digit idx
   always_comb begin
      w_nibble    = 4'h0;
      w_blank_cur = 1'b0;
      w_dp_cur    = 1'b0;
      w_onehot    = '0;
      for (int i = 0; i < c_digits; i++) begin
         if (idx_q == c_idx_w'(i)) begin
            w_nibble    = shadow_q[i*4 +: 4];
            w_blank_cur = w_blank[i];
            w_dp_cur    = dp_q[i];
            w_onehot[i] = 1'b1;
         end
      end
   end

   hex_to_7seg u_hex_to_7seg (
      .i_nibble (w_nibble),
      .o_seg_n  (w_seg)
   );

   // Scan sequencing: LOAD -> (GUARD_S -> SHOW) per digit -> LOAD
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      lz_en_d  = lz_en_q;
      dp_d     = dp_q;
      pend_d   = pend_q;
      case (state_q)
         LOAD: begin
            // Only place the inputs are sampled, so a frame never tears
            shadow_d = ToDisplay;
            lz_en_d  = blank_lz;
            dp_d     = dp_mask;
            idx_d    = '0;
            cnt_d    = '0;
            pend_d   = 1'b0;
            state_d  = GUARD_S;
         end
         GUARD_S: begin
            cnt_d = cnt_q + c_cnt_one;
            if (cnt_q == c_guard_last) begin
               state_d = SHOW;
            end
         end
         SHOW: begin
            if (cnt_q == c_slot_last) begin
               cnt_d = '0;
               if (idx_q == c_idx_last) begin
                  pend_d  = 1'b1;
                  state_d = LOAD;
               end else begin
                  idx_d   = idx_q + c_idx_one;
                  state_d = GUARD_S;
               end
            end else begin
               cnt_d = cnt_q + c_cnt_one;
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   // Pin drives for the next cycle, derived from the present FSM state
   always_comb begin
      anodes_d     = '1;
      segments_d   = SEG_BLANK;
      dp_out_d     = 1'b1;
      frame_done_d = (state_q == LOAD) && pend_q;
      if ((state_q == SHOW) && !w_blank_cur) begin
         anodes_d   = ~w_onehot;
         segments_d = w_seg;
         dp_out_d   = ~w_dp_cur;
      end
   end

   // State and output registers; reset forces every pin to its idle level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= LOAD;
         cnt_q        <= '0;
         idx_q        <= '0;
         shadow_q     <= '0;
         lz_en_q      <= 1'b0;
         dp_q         <= '0;
         pend_q       <= 1'b0;
         anodes_q     <= '1;
         segments_q   <= SEG_BLANK;
         dp_out_q     <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         lz_en_q      <= lz_en_d;
         dp_q         <= dp_d;
         pend_q       <= pend_d;
         anodes_q     <= anodes_d;
         segments_q   <= segments_d;
         dp_out_q     <= dp_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign anodes     = anodes_q;
   assign segments   = segments_q;
   assign dp         = dp_out_q;
   assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_hex_display_scan
//  Description : Scoreboard bench for hex_display_scan (N=16, REFRESH_DIV=8,
//                GUARD=2). Expected per-cycle pin values for a whole frame
//                are queued when a frame's inputs are applied and popped one
//                per cycle as the DUT drives its pins.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_display_scan;

   localparam int RD    = 8;
   localparam int GD    = 2;
   localparam int DG    = 4;
   localparam int FRAME = DG * RD + 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] ToDisplay = 16'h0;
   logic        blank_lz = 1'b0;
   logic [3:0]  dp_mask = 4'h0;
   logic [3:0]  anodes;
   logic [6:0]  segments;
   logic        dp;
   logic        frame_done;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   hex_display_scan #(
      .N           (16),
      .REFRESH_DIV (RD),
      .GUARD       (GD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ToDisplay  (ToDisplay),
      .blank_lz   (blank_lz),
      .dp_mask    (dp_mask),
      .anodes     (anodes),
      .segments   (segments),
      .dp         (dp),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Queue the expected pins for one frame, starting with the LOAD output cycle
   task automatic push_frame(input logic [15:0] v, input logic lz, input logic [3:0] dpm,
                             input logic fd_first);
      exp_t e;
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: fd_first};
      sb_q.push_back(e);
      for (int d = 0; d < DG; d++) begin
         logic [3:0] nib;
         logic       blank;
         nib   = v[d*4 +: 4];
         blank = lz && (d > 0) && ((v >> (4 * d)) == 16'h0);
         for (int k = 0; k < RD; k++) begin
            if (k < GD || blank) e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
            else                 e = '{an: ~(4'b0001 << d), seg: hex_tab[nib], dp: ~dpm[d], fd: 1'b0};
            sb_q.push_back(e);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (anodes !== 4'hF) $display("FAIL reset_anodes got %b want 1111", anodes); else n_pass++;
      n_checks++; if (segments !== 7'h7F) $display("FAIL reset_segments got %h want 7f", segments); else n_pass++;
      n_checks++; if (dp !== 1'b1) $display("FAIL reset_dp got %b want 1", dp); else n_pass++;
      n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_basic();
      exp_t e;
      ToDisplay = 16'h12AF; blank_lz = 1'b0; dp_mask = 4'h0;
      for (int f = 0; f < 2; f++) begin
         push_frame(16'h12AF, 1'b0, 4'h0, (f != 0));
         for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            n_checks++;
            if (sb_q.size() == 0) $display("FAIL basic scoreboard empty at cycle %0d", c);
            else begin
               e = sb_q.pop_front();
               if ({anodes, segments, dp, frame_done} !== e)
                  $display("FAIL basic f%0d c%0d got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                           f, c, anodes, segments, dp, frame_done, e.an, e.seg, e.dp, e.fd);
               else n_pass++;
            end
         end
      end
   endtask

   task automatic test_blanking();
      exp_t        e;
      logic [15:0] vals [3] = '{16'h0005, 16'h0000, 16'h0100};
      blank_lz = 1'b1; dp_mask = 4'h0;
      for (int f = 0; f < 3; f++) begin
         ToDisplay = vals[f];
         push_frame(vals[f], 1'b1, 4'h0, 1'b1);
         for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            n_checks++;
            if (sb_q.size() == 0) $display("FAIL blank scoreboard empty at cycle %0d", c);
            else begin
               e = sb_q.pop_front();
               if ({anodes, segments, dp, frame_done} !== e)
                  $display("FAIL blank v=%h c%0d got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                           vals[f], c, anodes, segments, dp, frame_done, e.an, e.seg, e.dp, e.fd);
               else n_pass++;
            end
         end
      end
   endtask

   task automatic test_no_tear();
      exp_t e;
      ToDisplay = 16'h1111; blank_lz = 1'b0; dp_mask = 4'h0;
      for (int f = 0; f < 2; f++) begin
         push_frame((f == 0) ? 16'h1111 : 16'h2222, 1'b0, 4'h0, 1'b1);
         for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            n_checks++;
            if (sb_q.size() == 0) $display("FAIL tear scoreboard empty at cycle %0d", c);
            else begin
               e = sb_q.pop_front();
               if ({anodes, segments, dp, frame_done} !== e)
                  $display("FAIL tear f%0d c%0d got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                           f, c, anodes, segments, dp, frame_done, e.an, e.seg, e.dp, e.fd);
               else n_pass++;
            end
            if (f == 0 && c == 15) ToDisplay = 16'h2222;
         end
      end
   endtask

   task automatic test_dp();
      exp_t e;
      ToDisplay = 16'h12AF; blank_lz = 1'b0; dp_mask = 4'b0100;
      push_frame(16'h12AF, 1'b0, 4'b0100, 1'b1);
      for (int c = 0; c < FRAME; c++) begin
         @(negedge clk);
         n_checks++;
         if (sb_q.size() == 0) $display("FAIL dp scoreboard empty at cycle %0d", c);
         else begin
            e = sb_q.pop_front();
            if ({anodes, segments, dp, frame_done} !== e)
               $display("FAIL dp c%0d got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                        c, anodes, segments, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      exp_t e;
      ToDisplay = 16'h4321; blank_lz = 1'b0; dp_mask = 4'b0100;
      push_frame(16'h4321, 1'b0, 4'b0100, 1'b1);
      // Cycle 21 lies inside digit 2's show interval
      for (int c = 0; c <= 21; c++) begin
         @(negedge clk);
         n_checks++;
         if (sb_q.size() == 0) $display("FAIL rstmid scoreboard empty at cycle %0d", c);
         else begin
            e = sb_q.pop_front();
            if ({anodes, segments, dp, frame_done} !== e)
               $display("FAIL rstmid pre c%0d got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                        c, anodes, segments, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            else n_pass++;
         end
      end
      reset = 1'b1;
      #1;
      n_checks++; if (anodes !== 4'hF) $display("FAIL rstmid_anodes got %b want 1111", anodes); else n_pass++;
      n_checks++; if (segments !== 7'h7F) $display("FAIL rstmid_segments got %h want 7f", segments); else n_pass++;
      n_checks++; if (dp !== 1'b1) $display("FAIL rstmid_dp got %b want 1", dp); else n_pass++;
      sb_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      push_frame(16'h4321, 1'b0, 4'b0100, 1'b0);
      for (int c = 0; c < FRAME; c++) begin
         @(negedge clk);
         n_checks++;
         if (sb_q.size() == 0) $display("FAIL rstmid scoreboard empty at cycle %0d", c);
         else begin
            e = sb_q.pop_front();
            if ({anodes, segments, dp, frame_done} !== e)
               $display("FAIL rstmid post c%0d got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                        c, anodes, segments, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            else n_pass++;
         end
      end
   endtask

   task automatic test_back_to_back();
      int last_fd = -1;
      int pulses  = 0;
      for (int c = 0; c < 4 * FRAME; c++) begin
         @(negedge clk);
         n_checks++;
         if ($countones(~anodes) > 1) $display("FAIL onehot c%0d anodes=%b want at most one low", c, anodes);
         else n_pass++;
         if (frame_done === 1'b1) begin
            if (last_fd >= 0) begin
               n_checks++;
               if (c - last_fd != FRAME) $display("FAIL fd_spacing got %0d want %0d", c - last_fd, FRAME);
               else n_pass++;
            end
            last_fd = c;
            pulses++;
         end
      end
      n_checks++;
      if (pulses != 4) $display("FAIL fd_count got %0d want 4", pulses); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_blanking();
      test_no_tear();
      test_dp();
      test_reset_mid_frame();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout after %0d checks", n_checks);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
